// File: rtl/inv_subbyte_iter.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE shared inverse S-box lookups walk the
// 128-bit state most-significant byte first, then hold the result until it is consumed.
module inv_subbyte_iter #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP = 5'(BYTES_PER_CYCLE);

    // Entry x of the inverse S-box sits at bits [2047-8x -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   sub_data;
    logic [4:0]     cnt_next;
    logic           accept;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = data_q;
    assign accept    = in_valid && in_ready;
    assign cnt_next  = cnt_q + STEP;

    // Only the group at the counter index is rewritten; all other bytes pass through.
    always_comb begin
        sub_data = data_q;
        for (int i = 0; i < int'(BYTES_PER_CYCLE); i++) begin
            sub_data[8 * (15 - int'(cnt_q[3:0]) - i) +: 8] =
                inv_sbox(data_q[8 * (15 - int'(cnt_q[3:0]) - i) +: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = 5'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                data_d = sub_data;
                cnt_d  = cnt_next;
                if (cnt_next == 5'd16) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Delivery and a new acceptance may share one edge.
                if (accept) begin
                    data_d  = in_data;
                    cnt_d   = 5'd0;
                    state_d = StRun;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            data_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_inv_subbyte_iter.sv
// Directed bench for inv_subbyte_iter: default instance plus BYTES_PER_CYCLE = 1, 2, 16
// instances, checked against hand-computed vectors and a forward S-box round trip.
module tb_inv_subbyte_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;

    logic         sw_in_valid, sw_out_ready;
    logic [127:0] sw_in_data;
    logic [2:0]   sw_in_ready, sw_out_valid, sw_busy;
    logic [127:0] sw_out_data [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inv_subbyte_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    inv_subbyte_iter #(.BYTES_PER_CYCLE(1)) dut_b1 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[0]),
        .in_data(sw_in_data), .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[0]), .busy(sw_busy[0])
    );

    inv_subbyte_iter #(.BYTES_PER_CYCLE(2)) dut_b2 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[1]),
        .in_data(sw_in_data), .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[1]), .busy(sw_busy[1])
    );

    inv_subbyte_iter #(.BYTES_PER_CYCLE(16)) dut_b16 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[2]),
        .in_data(sw_in_data), .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready),
        .out_data(sw_out_data[2]), .busy(sw_busy[2])
    );

    // Forward FIPS-197 S-box; entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [127:0] sub_fwd(input logic [127:0] x);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) begin
            r[127 - 8 * j -: 8] = FWD_SBOX[2047 - 8 * int'(x[127 - 8 * j -: 8]) -: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        if (in_ready !== 1'b1) check("wait_in_ready", 128'(in_ready), 128'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] exp);
        int lat;
        out_ready = 1'b1;
        in_data   = din;
        in_valid  = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, "_latency"}, 128'(lat), 128'd5);
        check({tag, "_data"}, out_data, exp);
        tick();
        check({tag, "_idle"}, {126'd0, out_valid, busy}, 128'd0);
    endtask

    task automatic run_sweep(input string tag, input logic [127:0] din, input logic [127:0] exp);
        int           lat [3];
        int           exp_lat [3] = '{17, 9, 2};
        logic [127:0] got [3];
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0;
            got[d] = '0;
        end
        sw_out_ready = 1'b1;
        sw_in_data   = din;
        sw_in_valid  = 1'b1;
        check({tag, "_ready"}, 128'(sw_in_ready), 128'h7);
        tick();
        sw_in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            for (int d = 0; d < 3; d++) begin
                if (lat[d] == 0 && sw_out_valid[d]) begin
                    lat[d] = c;
                    got[d] = sw_out_data[d];
                end
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_lat%0d", tag, d), 128'(lat[d]), 128'(exp_lat[d]));
            check($sformatf("%s_data%0d", tag, d), got[d], exp);
        end
        check({tag, "_idle"}, {125'd0, sw_busy}, 128'd0);
    endtask

    initial begin
        logic [127:0] a, a_exp, x;
        int           lat;
        logic         stable, seen;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        sw_in_valid = 1'b0; sw_in_data = '0; sw_out_ready = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        rst = 1'b0;

        run_one("vec", 128'h637c777bf26b6fc53001672bfed7ab76,
                128'h000102030405060708090a0b0c0d0e0f);
        run_one("all16", {16{8'h16}}, {16{8'hff}});
        run_one("zero", 128'h0, {16{8'h52}});

        // Every byte value once, via the forward S-box.
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) x[127 - 8 * j -: 8] = 8'(16 * k + j);
            run_one($sformatf("table%0d", k), sub_fwd(x), x);
        end

        // Backpressure in DONE; a competing in_valid must be ignored.
        a_exp = 128'h00112233445566778899aabbccddeeff;
        a     = sub_fwd(a_exp);
        out_ready = 1'b0; in_data = a; in_valid = 1'b1;
        wait_ready();
        tick();
        in_data = ~a;
        wait_valid(lat);
        check("bp_latency", 128'(lat), 128'd5);
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (out_data !== a_exp || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        check("bp_hold", 128'(stable), 128'd1);
        check("bp_data", out_data, a_exp);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_in_ready", 128'(in_ready), 128'd1);
        tick();
        check("bp_idle", {126'd0, out_valid, busy}, 128'd0);

        // Back-to-back: second block accepted on the first delivery edge.
        in_data = 128'h637c777bf26b6fc53001672bfed7ab76; in_valid = 1'b1;
        wait_ready();
        tick();
        in_data = 128'h0;
        wait_valid(lat);
        check("b2b_lat1", 128'(lat), 128'd5);
        check("b2b_data1", out_data, 128'h000102030405060708090a0b0c0d0e0f);
        check("b2b_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("b2b_spacing", 128'(lat), 128'd5);
        check("b2b_data2", out_data, {16{8'h52}});
        tick();
        check("b2b_idle", {126'd0, out_valid, busy}, 128'd0);

        // Reset mid-RUN.
        in_data = a; in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstrun_out_valid", 128'(out_valid), 128'd0);
        check("rstrun_busy", 128'(busy), 128'd0);
        check("rstrun_in_ready", 128'(in_ready), 128'd1);
        check("rstrun_out_data", out_data, 128'd0);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("rstrun_no_stale", 128'(seen), 128'd0);

        // Reset in DONE wins over a simultaneous delivery plus acceptance.
        out_ready = 1'b0; in_data = a; in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 128'h0; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rstdone_state", {126'd0, out_valid, busy}, 128'd0);
        check("rstdone_out_data", out_data, 128'd0);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("rstdone_no_stale", 128'(seen), 128'd0);

        x = {$urandom, $urandom, $urandom, $urandom};
        run_one("rand", sub_fwd(x), x);

        run_sweep("sw_vec", 128'h637c777bf26b6fc53001672bfed7ab76,
                  128'h000102030405060708090a0b0c0d0e0f);
        x = {$urandom, $urandom, $urandom, $urandom};
        run_sweep("sw_rand", sub_fwd(x), x);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_subbyte_iter.md
INV_SUBBYTE_ITER -- requirements
Module: inv_subbyte_iter

Interface
REQ-001 The module SHALL have parameter BYTES_PER_CYCLE, default 4, giving the number of bytes inverse-substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit: in_data is presented.
REQ-005 The module SHALL have port in_ready, output, 1 bit: block can accept in_data this cycle.
REQ-006 The module SHALL have port in_data, input, 128 bits: AES state after SubBytes; byte 0 = bits 127:120, byte 15 = bits 7:0.
REQ-007 The module SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-008 The module SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-009 The module SHALL have port out_data, output, 128 bits: InvSubBytes(in_data), same byte ordering as in_data.
REQ-010 The module SHALL have port busy, output, 1 bit: a transfer is accepted and not yet delivered.

Function
REQ-011 The module SHALL use the FIPS-197 inverse S-box (InvSbox), applied bytewise; InvSbox(S(x)) = x for every x in 0x00-0xFF.
REQ-012 The module SHALL implement exactly BYTES_PER_CYCLE inverse S-box lookups, shared across iterations; it SHALL NOT instantiate 16 lookups unless BYTES_PER_CYCLE = 16.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE: in_ready = 1, out_valid = 0, busy = 0.
REQ-015 An input transfer SHALL occur on a cycle with in_valid & in_ready; the block SHALL latch in_data into an internal 128-bit register, clear the byte counter to 0 and enter RUN.
REQ-016 RUN: each cycle the block SHALL replace the BYTES_PER_CYCLE bytes starting at the counter index, most-significant first, with their InvSbox values; the counter SHALL advance by BYTES_PER_CYCLE.
REQ-017 RUN SHALL last exactly 16/BYTES_PER_CYCLE cycles; after the last group the block SHALL enter DONE.
REQ-018 Latency: out_valid SHALL rise 16/BYTES_PER_CYCLE + 1 cycles after the accepting edge, i.e. 5 cycles for the default.
REQ-019 Counter width SHALL be 5 bits; the counter SHALL never wrap past 16 within one transfer.
REQ-020 RUN: in_ready = 0, out_valid = 0, busy = 1; in_valid and in_data SHALL be ignored.
REQ-021 DONE: out_valid = 1, busy = 1, and out_data SHALL hold stable until out_ready is sampled high.
REQ-022 DONE with out_ready = 1: the output transfer SHALL complete; in_ready = out_ready in DONE.
REQ-023 DONE with out_ready = 1 and in_valid = 1 (simultaneous events): the block SHALL accept the new in_data on the same edge and enter RUN, with no idle bubble.
REQ-024 DONE with out_ready = 1 and in_valid = 0: the block SHALL go to IDLE.
REQ-025 DONE with out_ready = 0: the block SHALL stay in DONE indefinitely; there SHALL be no timeout.
REQ-026 out_data SHALL be driven directly from the internal register; partially substituted data SHALL never be marked valid.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL enter IDLE, set out_valid = 0 and busy = 0, clear the byte counter to 0 and the data register to 128'h0 (so out_data = 0); in_ready SHALL be 1 after that edge.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the in-flight block; no out_valid SHALL follow for it.
REQ-029 Reset SHALL take priority over any simultaneous handshake on the same edge.

Verification
REQ-030 Single transfer: in_data = 128'h637c777bf26b6fc53001672bfed7ab76 with out_ready = 1 -> out_data = 128'h000102030405060708090a0b0c0d0e0f, out_valid 5 cycles after acceptance (default parameter).
REQ-031 Uniform byte: in_data = 128'h16161616161616161616161616161616 -> out_data = 128'hffffffffffffffffffffffffffffffff; in_data all 0x00 -> out_data all 0x52.
REQ-032 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_data stable, in_ready = 0, busy = 1; raise out_ready -> one transfer, then IDLE.
REQ-033 Back-to-back: keep in_valid = 1 with two blocks queued and out_ready = 1 -> second block accepted on the same edge as the first delivery; results spaced 5 cycles apart.
REQ-034 Reset mid-RUN: assert rst 2 cycles after acceptance -> next cycle out_valid = 0, busy = 0, in_ready = 1, out_data = 0; no stale result appears later.
REQ-035 Parameter sweep: BYTES_PER_CYCLE in {1, 2, 16} -> latency 17, 9 and 2 cycles respectively; for random inputs, the result SHALL equal the inverse of a forward SubBytes model.
